// File: rtl/alu32_if.sv
// Operand/opcode request and registered result bundle between datapath and ALU.
// The ALU never stalls, so the bundle carries no flow-control signals.
interface alu32_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       ALUopcode;
    logic [WIDTH-1:0] rega;
    logic [WIDTH-1:0] regb;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output ALUopcode,
        output rega,
        output regb,
        input  result,
        input  zero
    );

    modport slave (
        input  ALUopcode,
        input  rega,
        input  regb,
        output result,
        output zero
    );
endinterface

// File: rtl/alu32.sv
// Integer ALU (add/sub/and/or/sltu/slt/xor/nor), one cycle from operand sample to registered result.
// No backpressure: a new operation is accepted on every rising clock edge.
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    alu32_if.slave bus
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_SLTU = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_NOR  = 3'd7;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             lt_u, lt_s;

    // Comparisons use true magnitude compares so signed overflow cannot corrupt slt.
    assign lt_u = (bus.rega < bus.regb);
    assign lt_s = ($signed(bus.rega) < $signed(bus.regb));

    always_comb begin
        result_d = '0;
        case (bus.ALUopcode)
            OP_ADD:  result_d = bus.rega + bus.regb;
            OP_SUB:  result_d = bus.rega - bus.regb;
            OP_AND:  result_d = bus.rega & bus.regb;
            OP_OR:   result_d = bus.rega | bus.regb;
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_XOR:  result_d = bus.rega ^ bus.regb;
            OP_NOR:  result_d = ~(bus.rega | bus.regb);
            default: result_d = '0;
        endcase
        // Derived from the same value that gets registered, so flag and result cannot disagree.
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu32.sv
// Directed and randomized checks of alu32 against an arithmetic reference model.
module tb_alu32;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu32_if #(.WIDTH(32)) bus ();

    alu32 #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on widened/signed views of the operands.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ua;
        longint ub;
        int     sa;
        int     sb;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = int'(a);
        sb = int'(b);
        case (op)
            0: return 32'(ua + ub);
            1: return 32'(ua - ub);
            2: return a & b;
            3: return a | b;
            4: return (ua < ub) ? 32'd1 : 32'd0;
            5: return (sa < sb) ? 32'd1 : 32'd0;
            6: return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check_res(input string tag, input logic [31:0] exp_r, input logic exp_z);
        n_cmp++;
        assert (bus.result === exp_r) else begin
            n_bad++;
            $error("FAIL %s result: got %h want %h", tag, bus.result, exp_r);
        end
        n_cmp++;
        assert (bus.zero === exp_z) else begin
            n_bad++;
            $error("FAIL %s zero: got %b want %b", tag, bus.zero, exp_z);
        end
    endtask

    // Drive between edges, sample just after the capturing edge.
    task automatic step(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_r;
        @(negedge clk);
        bus.ALUopcode = 3'(op);
        bus.rega      = a;
        bus.regb      = b;
        exp_r = ref_alu(op, a, b);
        @(posedge clk);
        #1;
        check_res(tag, exp_r, exp_r == 32'h0);
    endtask

    // Spec-stated results, independent of the model.
    task automatic step_k(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
        @(negedge clk);
        bus.ALUopcode = 3'(op);
        bus.rega      = a;
        bus.regb      = b;
        @(posedge clk);
        #1;
        check_res(tag, want, want == 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corner [6];
        logic [31:0] a;
        logic [31:0] b;
        n_cmp = 0;
        n_bad = 0;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        corner[5] = 32'hFFFF_FFFE;

        // Reset behaviour
        rst_n         = 1'b0;
        bus.ALUopcode = 3'd0;
        bus.rega      = 32'd7;
        bus.regb      = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check_res("reset_hold", 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_res("reset_release", 32'd10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_res("reset_async", 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic and logic
        step_k("add_1_1",      0, 32'd1, 32'd1, 32'd2);
        step_k("add_wrap",     0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        step_k("sub_2_1",      1, 32'd2, 32'd1, 32'd1);
        step_k("sub_1_2",      1, 32'd1, 32'd2, 32'hFFFF_FFFF);
        step_k("sub_5_5",      1, 32'd5, 32'd5, 32'h0);
        step_k("and_5_1",      2, 32'd5, 32'd1, 32'd1);
        step_k("or_4_1",       3, 32'd4, 32'd1, 32'd5);
        step_k("xor_5_1",      6, 32'd5, 32'd1, 32'd4);
        step_k("nor_0_0",      7, 32'd0, 32'd0, 32'hFFFF_FFFF);

        // Unsigned compare
        step_k("sltu_4_5",     4, 32'd4, 32'd5, 32'd1);
        step_k("sltu_5_4",     4, 32'd5, 32'd4, 32'd0);
        step_k("sltu_m1_1",    4, 32'hFFFF_FFFF, 32'd1, 32'd0);

        // Signed compare
        step_k("slt_4_5",      5, 32'd4, 32'd5, 32'd1);
        step_k("slt_m1_m2",    5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0);
        step_k("slt_m2_m1",    5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1);
        step_k("slt_m1_0",     5, 32'hFFFF_FFFF, 32'd0, 32'd1);
        step_k("slt_0_m2",     5, 32'd0, 32'hFFFF_FFFE, 32'd0);
        step_k("slt_m1_m1",    5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        step_k("slt_0_2",      5, 32'd0, 32'd2, 32'd1);
        step_k("slt_1_0",      5, 32'd1, 32'd0, 32'd0);
        step_k("slt_9_5",      5, 32'd9, 32'd5, 32'd0);
        step_k("slt_min_max",  5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        step_k("slt_max_min",  5, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);

        // Every opcode over all corner operand pairs
        for (int op = 0; op < 8; op++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    step("corner", op, corner[i], corner[j]);

        // Back-to-back pipelining: new operation each cycle
        for (int k = 0; k < 8; k++)
            step("pipe", k, $urandom, $urandom);

        // Randomized operations, occasionally forcing equal or corner operands
        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 7) == 0) a = corner[$urandom_range(0, 5)];
            step("rand", int'($urandom_range(0, 7)), a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
